// File: rtl/down_asy.sv
// Ripple down counter: a chain of toggle flops, stage 0 clocked by clk and each
// later stage clocked by the true output of the stage before it.
`timescale 1ns/1ps

module down_asy_stage (
    input  logic stage_clk,
    input  logic reset,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples its inputs before any of them update.
    always_ff @(posedge stage_clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= ~q;
        end
    end

endmodule

module down_asy #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] stage_clk;

    // Rising edge of the previous stage's Q means it wrapped 0 -> 1, i.e. a borrow.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign stage_clk[i] = clk;
        end else begin : g_chain
            assign stage_clk[i] = count_out[i-1];
        end

        down_asy_stage u_stage (
            .stage_clk (stage_clk[i]),
            .reset     (reset),
            .q         (count_out[i])
        );
    end

endmodule

// File: tb/tb_down_asy.sv
// Directed bench for down_asy: reset hold, down-count sequence and wrap,
// mid-count async reset, long run against a modulo model, and a 4-bit instance.
`timescale 1ns/1ps

module tb_down_asy;

    logic       clk;
    logic       reset;
    logic       reset4;
    logic [1:0] cnt2;
    logic [3:0] cnt4;

    int   errors = 0;
    int   checks = 0;
    time  last_rise = 0;
    int   bit1_changes = 0;

    down_asy #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .count_out (cnt2)
    );

    down_asy #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset4),
        .count_out (cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bit 1 may only move in the same timestep as a rising edge of bit 0.
    always @(posedge cnt2[0]) last_rise = $time;

    always @(cnt2[1]) begin
        if (reset === 1'b1) begin
            bit1_changes++;
            check("bit1_on_bit0_rise", 32'($time), 32'(last_rise));
        end
    end

    initial begin
        logic [1:0] exp2;
        logic [3:0] exp4;

        reset  = 1'b1;
        reset4 = 1'b1;
        #1;
        reset  = 1'b0;
        reset4 = 1'b0;

        // Reset held for 200 ns with the clock running.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_hold", 32'(cnt2), 32'h0);
        end
        check("reset_hold_w4", 32'(cnt4), 32'h0);

        // Release midway between rising edges, then two full down-count laps.
        reset = 1'b1;
        check("release_no_edge", 32'(cnt2), 32'h0);
        tick(); check("seq_11", 32'(cnt2), 32'h3);
        tick(); check("seq_10", 32'(cnt2), 32'h2);
        tick(); check("seq_01", 32'(cnt2), 32'h1);
        tick(); check("seq_00", 32'(cnt2), 32'h0);
        tick(); check("wrap_11", 32'(cnt2), 32'h3);
        tick(); check("wrap_10", 32'(cnt2), 32'h2);
        tick(); check("wrap_01", 32'(cnt2), 32'h1);
        tick(); check("wrap_00", 32'(cnt2), 32'h0);

        // Count to 10, then clear between edges.
        tick(); check("pre_mid_11", 32'(cnt2), 32'h3);
        tick(); check("pre_mid_10", 32'(cnt2), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_reset_clear", 32'(cnt2), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_reset_hold", 32'(cnt2), 32'h0);
        end

        // Long run against the model (-n mod 4).
        reset = 1'b1;
        exp2  = 2'd0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            exp2 = exp2 - 2'd1;
            check("long_run", 32'(cnt2), 32'(exp2));
            check("long_run_known", 32'($isunknown(cnt2)), 32'h0);
        end
        check("bit1_activity", 32'(bit1_changes > 0), 32'h1);

        // Four-stage instance: 0000, 1111, 1110, 1101, ... back to 0000 after 16 edges.
        check("w4_reset", 32'(cnt4), 32'h0);
        reset4 = 1'b1;
        exp4   = 4'd0;
        for (int n = 1; n <= 16; n++) begin
            tick();
            exp4 = exp4 - 4'd1;
            check("w4_count", 32'(cnt4), 32'(exp4));
        end
        check("w4_wrap_0000", 32'(cnt4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound in case the clock or the run sequence stalls.
    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation exceeded 50000 ns");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
